// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake and writeback bus between the sequencer and its client.
interface alu_exec_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;

  modport master (
    output instr_valid, instr,
    input  instr_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Three-phase (IDLE/EXEC/WB) sequencer driving an external ALU from a 4x8 register file.
// Optional macro ALU_EXEC_R0_ZERO_EN hardwires r0 to zero.
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  alu_exec_ctrl_if.slave bus,
  input  logic        ld_en,
  input  logic [1:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_sel,
  input  logic [7:0]  alu_ans,
  input  logic        alu_cout,
  output logic        carry_flag,
  output logic        zero_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic [7:0] rf [4];
  logic [1:0] rd_q;
  logic [1:0] wb_addr_q;
  logic [7:0] result;
  logic       cout_q;
  logic       accept;

  function automatic logic [7:0] rf_read(input logic [1:0] a);
`ifdef ALU_EXEC_R0_ZERO_EN
    rf_read = (a == 2'd0) ? '0 : rf[a];
`else
    rf_read = rf[a];
`endif
  endfunction

  function automatic logic wr_ok(input logic [1:0] a);
`ifdef ALU_EXEC_R0_ZERO_EN
    wr_ok = (a != 2'd0);
`else
    wr_ok = (a == a);
`endif
  endfunction

  assign bus.instr_ready = rst_n && (state == IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign bus.wb_valid    = (state == WB);
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = result;
  assign dbg_data        = rf_read(dbg_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) rf[i] <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rd_q       <= '0;
      wb_addr_q  <= '0;
      result     <= '0;
      cout_q     <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= rf_read(bus.instr[3:2]);
        alu_b   <= rf_read(bus.instr[1:0]);
        alu_sel <= bus.instr[7:6];
        rd_q    <= bus.instr[5:4];
      end
      // wb_addr is captured here rather than driven from rd_q so it holds across the next accept
      if (state == EXEC) begin
        result    <= alu_ans;
        cout_q    <= alu_cout;
        wb_addr_q <= rd_q;
      end
      if (ld_en && wr_ok(ld_addr)) rf[ld_addr] <= ld_data;
      // Later assignment wins, so writeback overrides a same-address external load
      if (state == WB) begin
        if (wr_ok(wb_addr_q)) rf[wb_addr_q] <= result;
        zero_flag <= (result == 8'h00);
        if (!alu_sel[1]) carry_flag <= cout_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench: transaction-level model plus directed literal checks.
module tb_alu_exec_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] alu_a, alu_b, alu_ans;
  logic [1:0] alu_sel;
  logic       alu_cout;
  logic       carry_flag, zero_flag;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_ans    (alu_ans),
    .alu_cout   (alu_cout),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: sub reports carry when a <= b; logic ops report a fixed carry that must be ignored.
  function automatic logic [8:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    alu_fn = {1'b0, a} + {1'b0, b};
      2'd1:    alu_fn = {(a <= b), a - b};
      2'd2:    alu_fn = {1'b0, a & b};
      default: alu_fn = {1'b1, a | b};
    endcase
  endfunction

  always_comb {alu_cout, alu_ans} = alu_fn(alu_sel, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] m_rf [4];
  int         m_phase;
  logic [1:0] m_rd, m_op, m_wb_addr;
  logic [7:0] m_res, m_wb_data, sa, sb;
  logic       m_cout, m_carry, m_zero;

  function automatic logic [7:0] m_read(input logic [1:0] a);
`ifdef ALU_EXEC_R0_ZERO_EN
    m_read = (a == 2'd0) ? 8'h00 : m_rf[a];
`else
    m_read = m_rf[a];
`endif
  endfunction

  function automatic logic m_wr(input logic [1:0] a);
`ifdef ALU_EXEC_R0_ZERO_EN
    m_wr = (a != 2'd0);
`else
    m_wr = 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_phase = 0; m_rd = 0; m_op = 0; m_res = 0; m_cout = 0;
      m_wb_addr = 0; m_wb_data = 0; m_carry = 0; m_zero = 0;
    end else begin
      sa = m_read(bus.instr[3:2]);
      sb = m_read(bus.instr[1:0]);
      if (ld_en && m_wr(ld_addr)) m_rf[ld_addr] = ld_data;
      if (m_phase == 0) begin
        if (bus.instr_valid) begin
          m_op = bus.instr[7:6];
          m_rd = bus.instr[5:4];
          {m_cout, m_res} = alu_fn(m_op, sa, sb);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_wb_addr = m_rd;
        m_wb_data = m_res;
        m_phase = 2;
      end else begin
        if (m_wr(m_rd)) m_rf[m_rd] = m_res;
        m_zero = (m_res == 8'h00);
        if (m_op < 2) m_carry = m_cout;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("m_ready",  bus.instr_ready, rst_n && (m_phase == 0));
    check("m_wbval",  bus.wb_valid,    (m_phase == 2));
    check("m_wbaddr", bus.wb_addr,     m_wb_addr);
    check("m_wbdata", bus.wb_data,     m_wb_data);
    check("m_carry",  carry_flag,      m_carry);
    check("m_zero",   zero_flag,       m_zero);
    check("m_dbg",    dbg_data,        m_read(dbg_addr));
  end

  // ---------------- directed stimulus ----------------
  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    sync();
    ld_en = 1'b0;
  endtask

  task automatic run_instr(input logic [7:0] x, input logic [7:0] exp_data,
                           input logic exp_c, input logic exp_z);
    bus.instr_valid = 1'b1; bus.instr = x;
    @(negedge clk) check("ri_ready", bus.instr_ready, 1'b1);
    sync();
    bus.instr_valid = 1'b0;
    @(negedge clk) check("ri_exec_nowb", bus.wb_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("ri_wbvalid", bus.wb_valid, 1'b1);
    check("ri_wbaddr",  bus.wb_addr,  x[5:4]);
    check("ri_wbdata",  bus.wb_data,  exp_data);
    sync();
    dbg_addr = x[5:4];
    @(negedge clk);
    check("ri_regfile", dbg_data,   exp_data);
    check("ri_carry",   carry_flag, exp_c);
    check("ri_zero",    zero_flag,  exp_z);
    sync();
  endtask

  logic [7:0] seq [3];
  int accepts, ready_cycles;

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.instr_ready, 1'b0);
    check("rst_wbval", bus.wb_valid, 1'b0);
    sync();
    rst_n = 1'b1;
    // first edge after release must accept
    run_instr(8'h36, 8'h00, 1'b0, 1'b1);

    load(2'd1, 8'hF0);
    load(2'd2, 8'h20);
    run_instr(8'h36, 8'h10, 1'b1, 1'b0);
    run_instr(8'h76, 8'hD0, 1'b0, 1'b0);
    run_instr(8'h75, 8'h00, 1'b1, 1'b1);
    run_instr(8'h36, 8'h10, 1'b1, 1'b0);
    run_instr(8'hB6, 8'h20, 1'b1, 1'b0);
    run_instr(8'h76, 8'hD0, 1'b0, 1'b0);
    run_instr(8'hF6, 8'hF0, 1'b0, 1'b0);

    // instr_valid held high for 9 cycles
    seq[0] = 8'h36; seq[1] = 8'h0D; seq[2] = 8'h9C;
    accepts = 0; ready_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      bus.instr_valid = 1'b1; bus.instr = seq[i/3];
      @(negedge clk);
      if (bus.instr_ready) ready_cycles++;
      if (bus.instr_ready && bus.instr_valid) accepts++;
      sync();
    end
    bus.instr_valid = 1'b0;
    check("hold_accepts", accepts, 3);
    check("hold_ready_cycles", ready_cycles, 3);
    dbg_addr = 2'd1;
    @(negedge clk) check("hold_r1", dbg_data, 8'h00);
    sync();

    // load on accept edge reads old operands; load on WB edge loses to writeback
    load(2'd1, 8'hF0);
    bus.instr_valid = 1'b1; bus.instr = 8'h36;
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h01;
    sync();
    bus.instr_valid = 1'b0; ld_en = 1'b0;
    sync();
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'hAA;
    @(negedge clk) check("acc_ld_wbdata", bus.wb_data, 8'h10);
    sync();
    ld_en = 1'b0; dbg_addr = 2'd3;
    @(negedge clk) check("wb_beats_ld", dbg_data, 8'h10);
    sync();
    dbg_addr = 2'd1;
    @(negedge clk) check("ld_on_accept", dbg_data, 8'h01);
    sync();

    // reset during EXEC aborts the instruction
    bus.instr_valid = 1'b1; bus.instr = 8'h36;
    sync();
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.instr_ready, 1'b0);
    check("abort_wbval", bus.wb_valid, 1'b0);
    sync();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) check("abort_no_wb", bus.wb_valid, 1'b0);
      sync();
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      @(negedge clk) check("abort_reg_zero", dbg_data, 8'h00);
      sync();
    end
    check("abort_carry", carry_flag, 1'b0);
    check("abort_zero", zero_flag, 1'b0);

    load(2'd0, 8'h55);
`ifdef ALU_EXEC_R0_ZERO_EN
    run_instr(8'h00, 8'h00, 1'b0, 1'b1);
`else
    run_instr(8'h00, 8'hAA, 1'b0, 1'b0);
`endif

    repeat (2) sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
